// File: rtl/iecdrv_pkg.sv
// Shared types, constants and helpers for the drive ROM slot multiplexer.
package iecdrv_pkg;

  // Size codes: a set bit keeps the corresponding upper address bit.
  localparam logic [1:0] ROM_SZ_8K  = 2'b00;
  localparam logic [1:0] ROM_SZ_16K = 2'b01;
  localparam logic [1:0] ROM_SZ_32K = 2'b11;

  typedef logic [2:0] rom_sel_t;

  // Counter width able to hold the idle value NREQ+RD_LAT+1.
  function automatic int unsigned slot_cnt_w(input int unsigned nreq, input int unsigned rd_lat);
    return $clog2(nreq + rd_lat + 2);
  endfunction

endpackage

// File: rtl/iecdrv_slot_timer.sv
// Frame slot counter: restarts on frame_start, saturates at T (idle), flags overruns.
module iecdrv_slot_timer #(
  parameter int unsigned T  = 7,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          overrun_clr,
  output logic [CW-1:0] cnt,
  output logic          busy,
  output logic          overrun
);

  logic [CW-1:0] cnt_nxt_c;

  // Next slot: restart on frame sync, otherwise count up to the idle value.
  always_comb begin
    cnt_nxt_c = cnt;
    if (frame_start) begin
      cnt_nxt_c = '0;
    end else if (cnt != CW'(T)) begin
      cnt_nxt_c = cnt + CW'(1);
    end
  end

  // Counter, busy and sticky overrun registers; a new overrun beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= CW'(T);
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt  <= cnt_nxt_c;
      busy <= (cnt_nxt_c != CW'(T));
      if (frame_start && busy) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iecdrv_rom_slot_mux.sv
// Time-slot arbiter sharing one set of drive ROMs among NREQ drive CPUs.
module iecdrv_rom_slot_mux
  import iecdrv_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned NROM    = 4,
  parameter  int unsigned AW      = 15,
  parameter  int unsigned BASE_AW = 13,
  parameter  int unsigned DW      = 8,
  parameter  int unsigned RD_LAT  = 2,
  localparam int unsigned SZW     = AW - BASE_AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [NREQ-1:0]      req_en,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*3-1:0]    req_rom_sel,
  input  logic [NROM*SZW-1:0]  rom_sz,
  output logic [AW-1:0]        mem_addr,
  input  logic [NROM*DW-1:0]   rom_q,
  output logic [NREQ*DW-1:0]   rsp_data,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int unsigned CW   = slot_cnt_w(NREQ, RD_LAT);
  localparam int unsigned T    = NREQ + RD_LAT + 1;
  localparam int unsigned SELW = $bits(rom_sel_t);

  logic [CW-1:0]   cnt;
  rom_sel_t        sel_eff_c [NREQ];
  rom_sel_t        sel_q     [NREQ];
  logic [NREQ-1:0] issue_c;
  logic [NREQ-1:0] capture_c;
  logic [NREQ-1:0] issued;
  logic [AW-1:0]   issue_addr_c;

  iecdrv_slot_timer #(
    .T  (T),
    .CW (CW)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .overrun_clr (overrun_clr),
    .cnt         (cnt),
    .busy        (busy),
    .overrun     (overrun)
  );

  // Slot decode, select sanitising and size-masked issue address.
  always_comb begin
    issue_c      = '0;
    capture_c    = '0;
    issue_addr_c = mem_addr;
    for (int i = 0; i < NREQ; i++) begin
      sel_eff_c[i] = rom_sel_t'(req_rom_sel[i*SELW +: SELW]);
      if (32'(sel_eff_c[i]) >= NROM) begin
        sel_eff_c[i] = '0;
      end
      issue_c[i]   = req_en[i] && !frame_start && (cnt == CW'(i));
      capture_c[i] = issued[i] && (cnt == CW'(i + 1 + RD_LAT));
      if (issue_c[i]) begin
        issue_addr_c = {req_addr[i*AW + BASE_AW +: SZW] & rom_sz[32'(sel_eff_c[i])*SZW +: SZW],
                        req_addr[i*AW +: BASE_AW]};
      end
    end
  end

  // Issue/capture registers; issued bits restart with every frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
      issued    <= '0;
      for (int i = 0; i < NREQ; i++) begin
        sel_q[i] <= '0;
      end
    end else begin
      mem_addr  <= issue_addr_c;
      rsp_valid <= capture_c;
      for (int i = 0; i < NREQ; i++) begin
        if (capture_c[i]) begin
          rsp_data[i*DW +: DW] <= rom_q[32'(sel_q[i])*DW +: DW];
        end
      end
      if (frame_start) begin
        issued <= '0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (issue_c[i]) begin
            issued[i] <= 1'b1;
            sel_q[i]  <= sel_eff_c[i];
          end
        end
      end
    end
  end

endmodule
